// File: rtl/axi4_lite_dmem_slave.sv
// AXI4-Lite responder for the data-memory window: byte-strobed word RAM, independent read/write FSMs.
// Optional macro AXI_DMEM_WAIT_STATES_EN inserts WAIT_CYCLES extra response latency on both channels.
module axi4_lite_dmem_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                    WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready
);

  localparam int                  IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] SPAN   = (ADDR_WIDTH+1)'(MEM_DEPTH) << 2;
  localparam logic [1:0]          OKAY   = 2'b00;
  localparam logic [1:0]          SLVERR = 2'b10;

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_param_check
    $error("axi4_lite_dmem_slave: WAIT_CYCLES must be 1..15 and MEM_DEPTH a power of two");
  end

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ({1'b0, off} < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} r_state_t;

  w_state_t w_state, w_state_n;
  r_state_t r_state, r_state_n;

  logic                  aw_done, aw_done_n, w_done, w_done_n;
  logic                  awready_n, wready_n, bvalid_n, arready_n, rvalid_n;
  logic [1:0]            bresp_n;
  logic                  aw_take, w_take, ar_take;
  logic                  w_first, mem_we, r_load;
  logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [31:0]           mem [MEM_DEPTH];

`ifdef AXI_DMEM_WAIT_STATES_EN
  logic [3:0] wcnt, wcnt_n, rcnt, rcnt_n;
`endif

  // write channel: next-state and registered-output values
  always_comb begin
    w_state_n = w_state;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    awready_n = s_awready;
    wready_n  = s_wready;
    bvalid_n  = s_bvalid;
    bresp_n   = s_bresp;
    aw_take   = 1'b0;
    w_take    = 1'b0;
    w_first   = 1'b0;
    mem_we    = 1'b0;
`ifdef AXI_DMEM_WAIT_STATES_EN
    wcnt_n    = wcnt;
`endif
    case (w_state)
      W_IDLE: begin
        aw_take   = s_awvalid && s_awready;
        w_take    = s_wvalid && s_wready;
        aw_done_n = aw_done || aw_take;
        w_done_n  = w_done || w_take;
        awready_n = !aw_done_n;
        wready_n  = !w_done_n;
        if (aw_done_n && w_done_n) begin
          w_state_n = W_EXEC;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
`ifdef AXI_DMEM_WAIT_STATES_EN
          wcnt_n    = '0;
`endif
        end
      end
      W_EXEC: begin
`ifdef AXI_DMEM_WAIT_STATES_EN
        w_first = (wcnt == '0);
        if (wcnt == 4'(WAIT_CYCLES)) begin
          w_state_n = W_RESP;
          bvalid_n  = 1'b1;
          bresp_n   = in_range(awaddr_q) ? OKAY : SLVERR;
        end else begin
          wcnt_n = wcnt + 4'd1;
        end
`else
        w_first   = 1'b1;
        w_state_n = W_RESP;
        bvalid_n  = 1'b1;
        bresp_n   = in_range(awaddr_q) ? OKAY : SLVERR;
`endif
        mem_we = w_first && in_range(awaddr_q);
      end
      W_RESP: begin
        if (s_bready) begin
          w_state_n = W_IDLE;
          bvalid_n  = 1'b0;
          bresp_n   = OKAY;
          awready_n = 1'b1;
          wready_n  = 1'b1;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  // read channel: a read is held off while the write FSM is committing to the array
  always_comb begin
    r_state_n = r_state;
    arready_n = s_arready;
    rvalid_n  = s_rvalid;
    ar_take   = 1'b0;
    r_load    = 1'b0;
`ifdef AXI_DMEM_WAIT_STATES_EN
    rcnt_n    = rcnt;
`endif
    case (r_state)
      R_IDLE: begin
        arready_n = 1'b1;
        ar_take   = s_arvalid && s_arready;
        if (ar_take) begin
          arready_n = 1'b0;
          r_state_n = R_ADDR;
`ifdef AXI_DMEM_WAIT_STATES_EN
          rcnt_n    = '0;
`endif
        end
      end
      R_ADDR: begin
        if (!w_first) begin
`ifdef AXI_DMEM_WAIT_STATES_EN
          if (rcnt == 4'(WAIT_CYCLES)) r_load = 1'b1;
          else                         rcnt_n = rcnt + 4'd1;
`else
          r_load = 1'b1;
`endif
          if (r_load) begin
            r_state_n = R_RESP;
            rvalid_n  = 1'b1;
          end
        end
      end
      R_RESP: begin
        if (s_rready) begin
          r_state_n = R_IDLE;
          rvalid_n  = 1'b0;
          arready_n = 1'b1;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  // control state and outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state   <= W_IDLE;
      r_state   <= R_IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= OKAY;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= OKAY;
`ifdef AXI_DMEM_WAIT_STATES_EN
      wcnt      <= '0;
      rcnt      <= '0;
`endif
    end else begin
      w_state   <= w_state_n;
      r_state   <= r_state_n;
      aw_done   <= aw_done_n;
      w_done    <= w_done_n;
      s_awready <= awready_n;
      s_wready  <= wready_n;
      s_bvalid  <= bvalid_n;
      s_bresp   <= bresp_n;
      s_arready <= arready_n;
      s_rvalid  <= rvalid_n;
`ifdef AXI_DMEM_WAIT_STATES_EN
      wcnt      <= wcnt_n;
      rcnt      <= rcnt_n;
`endif
      if (r_load) begin
        if (in_range(araddr_q)) begin
          s_rdata <= mem[word_idx(araddr_q)];
          s_rresp <= OKAY;
        end else begin
          s_rdata <= '0;
          s_rresp <= SLVERR;
        end
      end
    end
  end

  // captured request fields
  always_ff @(posedge clk) begin
    if (aw_take) awaddr_q <= s_awaddr;
    if (w_take) begin
      wdata_q <= s_wdata;
      wstrb_q <= s_wstrb;
    end
    if (ar_take) araddr_q <= s_araddr;
  end

  // word array; a reset landing on the commit cycle cancels the write
  always_ff @(posedge clk) begin
    if (mem_we && rst) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[word_idx(awaddr_q)][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule
